// File: rtl/mmu_arb_pkg.sv
// Shared definitions for the two-requester MMU arbiter: FSM state encoding,
// requester identifiers and the round-robin grant helper.
package mmu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   localparam logic REQ_CORE  = 1'b0;
   localparam logic REQ_ACCEL = 1'b1;

   // A lone request is granted directly; on a tie the requester that did not
   // hold the last grant wins.
   function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
      if (req0 && req1) begin
         return ~last;
      end else if (req1) begin
         return REQ_ACCEL;
      end else begin
         return REQ_CORE;
      end
   endfunction

endpackage

// File: rtl/mmu_xlate.sv
// Combinational address translation: keeps the low PA_W bits as the physical
// address and flags any set bit above them as an out-of-range fault.
module mmu_xlate #(
   parameter int PA_W = 24
) (
   input  logic [31:0] addr,
   output logic [31:0] phys,
   output logic        fault
);

   localparam logic [31:0] PA_MASK = 32'hFFFF_FFFF >> (32 - PA_W);

   assign phys  = addr & PA_MASK;
   assign fault = |(addr & ~PA_MASK);

endmodule

// File: rtl/mmu_arbiter.sv
// Round-robin arbiter granting a DLX core (r0) and an accelerator (r1) access
// to one memory port, with address range checking and a bounded wait for the
// memory acknowledge.
module mmu_arbiter
   import mmu_arb_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int PA_W    = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        r0_req,
   input  logic        r0_we,
   input  logic [31:0] r0_addr,
   input  logic [31:0] r0_wdata,
   output logic        r0_ack,
   output logic        r0_err,
   output logic [31:0] r0_rdata,
   input  logic        r1_req,
   input  logic        r1_we,
   input  logic [31:0] r1_addr,
   input  logic [31:0] r1_wdata,
   output logic        r1_ack,
   output logic        r1_err,
   output logic [31:0] r1_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        owner
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_t        state_q;
   arb_state_t        state_d;
   logic              owner_q;
   logic              we_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              any_req;
   logic              grant;
   logic              timeout;
   logic [31:0]       phys_addr;
   logic              range_fault;

   assign any_req = r0_req | r1_req;
   assign grant   = rr_pick(r0_req, r1_req, owner_q);
   // The final WAIT cycle is the one in which the count would reach TIMEOUT.
   assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

   mmu_xlate #(
      .PA_W (PA_W)
   ) u_xlate (
      .addr  (addr_q),
      .phys  (phys_addr),
      .fault (range_fault)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Transaction context: grant owner, latched request, wait counter, result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner_q <= REQ_ACCEL;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  owner_q <= grant;
                  we_q    <= (grant == REQ_ACCEL) ? r1_we    : r0_we;
                  addr_q  <= (grant == REQ_ACCEL) ? r1_addr  : r0_addr;
                  wdata_q <= (grant == REQ_ACCEL) ? r1_wdata : r0_wdata;
                  err_q   <= 1'b0;
               end
            end
            ISSUE: begin
               cnt_q <= '0;
               err_q <= range_fault;
            end
            WAIT: begin
               cnt_q <= cnt_q + CNT_W'(1);
               // An acknowledge arriving with the timeout still completes normally.
               if (mem_ack) begin
                  rdata_q <= mem_rdata;
               end else if (timeout) begin
                  err_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state decode plus the memory request and requester completion pulses.
   always_comb begin
      state_d  = state_q;
      mem_req  = 1'b0;
      r0_ack   = 1'b0;
      r0_err   = 1'b0;
      r0_rdata = '0;
      r1_ack   = 1'b0;
      r1_err   = 1'b0;
      r1_rdata = '0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // An out-of-range address never reaches memory.
            if (range_fault) begin
               state_d = RESP;
            end else begin
               mem_req = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            mem_req = 1'b1;
            if (mem_ack || timeout) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
            if (owner_q == REQ_CORE) begin
               r0_ack   = ~err_q;
               r0_err   = err_q;
               r0_rdata = err_q ? '0 : rdata_q;
            end else begin
               r1_ack   = ~err_q;
               r1_err   = err_q;
               r1_rdata = err_q ? '0 : rdata_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_addr  = mem_req ? phys_addr : '0;
   assign mem_we    = mem_req & we_q;
   assign mem_wdata = mem_req ? wdata_q : '0;
   assign busy      = (state_q != IDLE);
   assign owner     = owner_q;

endmodule

// File: doc/mmu_arbiter.md
MMU_ARBITER -- requirements
Module: mmu_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max cycles waiting for mem_ack before error completion.
REQ-002 SHALL have parameter PA_W, default 24: physical address bits passed to memory; bits 31:PA_W forced to 0.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have r0_req  input  1  DLX core access request, level, held until r0_ack/r0_err.
REQ-006 SHALL have r0_we, r0_addr[31:0], r0_wdata[31:0]  input  write enable, virtual address, write data; stable while r0_req high.
REQ-007 SHALL have r0_ack, r0_err  output  1 each  one-cycle completion / fault pulse.
REQ-008 SHALL have r0_rdata  output  32  read data, valid in r0_ack cycle.
REQ-009 SHALL have r1_req, r1_we, r1_addr[31:0], r1_wdata[31:0], r1_ack, r1_err, r1_rdata[31:0]  same directions/widths/meaning, accelerator requester.
REQ-010 SHALL have mem_req  output  1, mem_we  output  1, mem_addr  output  32, mem_wdata  output  32: memory request, held until mem_ack.
REQ-011 SHALL have mem_ack  input  1, mem_rdata  input  32: memory completion pulse and read data.
REQ-012 SHALL have busy  output  1 (state != IDLE) and owner  output  1 (requester of current/last grant).

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-014 IDLE: if any req, SHALL select a requester, latch its we/addr/wdata, go ISSUE next cycle; else stay IDLE.
REQ-015 Arbitration SHALL be round-robin: on simultaneous r0_req and r1_req, grant requester != owner; single request granted directly.
REQ-016 Address translation SHALL be mem_addr = {zeros(32-PA_W), latched_addr[PA_W-1:0]}.
REQ-017 If latched_addr[31:PA_W] != 0, SHALL skip memory, go RESP with error (out-of-range fault); mem_req never asserted.
REQ-018 ISSUE: mem_req=1 with latched fields, go WAIT; mem_req stays 1 through WAIT until mem_ack.
REQ-019 WAIT: on mem_ack, SHALL capture mem_rdata, deassert mem_req same edge, go RESP.
REQ-020 WAIT cycle counter (width clog2(TIMEOUT+1)) SHALL clear on entry, increment each WAIT cycle; reaching TIMEOUT with no mem_ack SHALL drop mem_req and go RESP with error.
REQ-021 mem_ack and timeout in same cycle: mem_ack wins (normal completion).
REQ-022 RESP: exactly one of rX_ack/rX_err pulses for the owner for one cycle; rX_rdata = captured data on ack, 0 on err; then IDLE.
REQ-023 Non-owner ack/err SHALL remain 0; a requester dropping req mid-transaction SHALL NOT abort it.
REQ-024 Minimum latency req->ack SHALL be 4 cycles when mem_ack arrives first WAIT cycle; back-to-back grants need one IDLE cycle.
REQ-025 mem_ack outside WAIT SHALL be ignored.

Reset
REQ-026 rst_n low at clk edge SHALL force IDLE, owner=1 (so r0 wins first tie), counter=0, all outputs 0 incl. mem_req, acks, errs, rdata, busy.
REQ-027 Reset mid-transaction SHALL abandon it without ack/err; mem_req low next cycle.

Structure
REQ-028 FSM state encoding and requester IDs (REQ_CORE=0, REQ_ACCEL=1) SHALL live in shared package mmu_arb_pkg.
REQ-029 Address translation SHALL be a combinational sub-module mmu_xlate (addr in, phys addr + range-fault out), instantiated once.

Verification
REQ-030 r0 read 0x00001234, mem_ack first WAIT cycle, mem_rdata 0xCAFEF00D -> mem_addr 0x00001234, r0_ack + r0_rdata 0xCAFEF00D on cycle 4.
REQ-031 r0,r1 asserted simultaneously after reset, three repeated rounds -> grant order r0,r1,r0,r1,r0,r1.
REQ-032 r1 write 0x05ABCDEF -> r1_err pulse, rdata 0, mem_req never high.
REQ-033 mem_ack withheld, TIMEOUT=64 -> r0_err after 64 WAIT cycles, mem_req low; mem_ack on cycle 64 instead -> r0_ack.
REQ-034 rst_n low during WAIT -> no ack/err, mem_req 0 next cycle, next request granted from IDLE normally.
